// File: rtl/sdrc_app_resp_if.sv
// Application-side request/data bus of the sdrc core, shared by masters and
// the RAM-backed responder.
interface sdrc_app_resp_if #(
  parameter int APP_DW = 32
);
  logic                  app_req;
  logic [29:0]           app_req_addr;
  logic [8:0]            app_req_len;
  logic                  app_req_wr_n;
  logic                  app_req_ack;
  logic [APP_DW-1:0]     app_wr_data;
  logic [APP_DW/8-1:0]   app_wr_en_n;
  logic                  app_wr_next_req;
  logic [APP_DW-1:0]     app_rd_data;
  logic                  app_rd_valid;
  logic                  sdr_core_busy_n;

  modport master (
    output app_req, app_req_addr, app_req_len, app_req_wr_n,
    output app_wr_data, app_wr_en_n,
    input  app_req_ack, app_wr_next_req, app_rd_data, app_rd_valid,
    input  sdr_core_busy_n
  );

  modport slave (
    input  app_req, app_req_addr, app_req_len, app_req_wr_n,
    input  app_wr_data, app_wr_en_n,
    output app_req_ack, app_wr_next_req, app_rd_data, app_rd_valid,
    output sdr_core_busy_n
  );
endinterface

// File: rtl/sdrc_app_resp.sv
// RAM-backed stand-in for sdrc_core on the application request interface.
// Define SDRC_APP_RESP_BP_EN to insert a one-cycle bubble after every data beat.
module sdrc_app_resp #(
  parameter int APP_DW = 32,
  parameter int MEM_AW = 8,
  parameter int RD_LAT = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  sdrc_app_resp_if.slave   app
);

  localparam int NB    = APP_DW / 8;
  localparam int DEPTH = 1 << MEM_AW;
  localparam logic [2:0] WAIT_INIT = 3'(RD_LAT - 1);
  localparam logic [MEM_AW-1:0] ADDR_STEP = MEM_AW'(1);

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    WR,
    RWAIT,
    RD
  } state_t;

  state_t              state_q, state_d;
  logic [MEM_AW-1:0]   addr_q, addr_d;
  logic [8:0]          len_q, len_d;
  logic [8:0]          beat_q, beat_d;
  logic                wr_n_q, wr_n_d;
  logic [2:0]          wait_q, wait_d;
  logic                beat_active;
  logic                wr_beat;
  logic                rd_beat;
  logic                rd_issue;
  logic [APP_DW-1:0]   mem [DEPTH];
  logic [APP_DW-1:0]   rd_data_q;
  logic                unused_addr_hi;

  assign unused_addr_hi = ^app.app_req_addr[29:MEM_AW];

`ifdef SDRC_APP_RESP_BP_EN
  logic toggle_q, toggle_d;

  // Phase restarts on entry to a data state so the first beat is never a bubble.
  always_comb begin
    toggle_d = ~toggle_q;
    if ((state_d == WR || state_d == RD) && state_d != state_q)
      toggle_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) toggle_q <= 1'b0;
    else          toggle_q <= toggle_d;
  end

  assign beat_active = ~toggle_q;
`else
  assign beat_active = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      wr_n_q  <= 1'b1;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      wr_n_q  <= wr_n_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    beat_d   = beat_q;
    wr_n_d   = wr_n_q;
    wait_d   = wait_q;
    wr_beat  = 1'b0;
    rd_beat  = 1'b0;
    rd_issue = 1'b0;

    case (state_q)
      IDLE: begin
        if (app.app_req) begin
          addr_d  = app.app_req_addr[MEM_AW-1:0];
          len_d   = app.app_req_len;
          wr_n_d  = app.app_req_wr_n;
          state_d = ACK;
        end
      end

      ACK: begin
        beat_d = len_q;
        if (len_q == 9'd0) begin
          state_d = IDLE;
        end else if (!wr_n_q) begin
          state_d = WR;
        end else begin
          wait_d  = WAIT_INIT;
          state_d = RWAIT;
        end
      end

      WR: begin
        if (beat_active) begin
          wr_beat = 1'b1;
          addr_d  = addr_q + ADDR_STEP;
          beat_d  = beat_q - 9'd1;
          if (beat_q == 9'd1) state_d = IDLE;
        end
      end

      // The RAM output is registered, so the first word is fetched one cycle early.
      RWAIT: begin
        if (wait_q == 3'd0) begin
          rd_issue = 1'b1;
          state_d  = RD;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end

      RD: begin
        if (beat_active) begin
          rd_beat = 1'b1;
          beat_d  = beat_q - 9'd1;
          if (beat_q == 9'd1) state_d = IDLE;
        end
`ifdef SDRC_APP_RESP_BP_EN
        rd_issue = ~beat_active;
`else
        rd_issue = (beat_q != 9'd1);
`endif
      end

      default: state_d = IDLE;
    endcase

    if (rd_issue) addr_d = addr_q + ADDR_STEP;
  end

  always_ff @(posedge clk) begin
    if (wr_beat) begin
      for (int i = 0; i < NB; i++) begin
        if (!app.app_wr_en_n[i]) mem[addr_q][i*8 +: 8] <= app.app_wr_data[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      rd_data_q <= '0;
    else if (rd_issue) rd_data_q <= mem[addr_q];
  end

  // Strobes decode the state register directly so a reset clears them at once.
  assign app.app_req_ack     = (state_q == ACK);
  assign app.app_wr_next_req = wr_beat;
  assign app.app_rd_valid    = rd_beat;
  assign app.app_rd_data     = rd_data_q;
  assign app.sdr_core_busy_n = (state_q == IDLE);

endmodule

// File: tb/tb_sdrc_app_resp.sv
// Scoreboard bench for sdrc_app_resp: a behavioural RAM model predicts every
// read beat and the handshake timing of each transfer.
module tb_sdrc_app_resp;

  localparam int RD_LAT = 2;

  logic clk;
  logic reset_n;

  sdrc_app_resp_if #(.APP_DW(32)) bus ();

  sdrc_app_resp #(
    .APP_DW(32),
    .MEM_AW(8),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .app     (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passed = 0;
  logic [31:0] model [256];
  logic [31:0] wbuf  [16];
  logic [31:0] exp_q [$];

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] en_n);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++)
      if (!en_n[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

  // Called on a negedge; returns on the negedge where the ack is visible.
  // The cycle in which app_req rises counts as cycle 1.
  task automatic issue_req(input logic [29:0] addr, input int len, input logic wr_n);
    int lat;
    bit seen;
    bus.app_req      = 1'b1;
    bus.app_req_addr = addr;
    bus.app_req_len  = 9'(len);
    bus.app_req_wr_n = wr_n;
    lat  = 1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (bus.app_req_ack) seen = 1'b1;
    end
    bus.app_req = 1'b0;
    checks++;
    if (!seen || lat != 2)
      $display("[TB] FAIL ack_latency addr=%0h: got %0d cycles (seen=%0b), expected 2", addr, lat, seen);
    else passed++;
  endtask

  task automatic write_burst(input logic [29:0] addr, input int len, input logic [3:0] en_n);
    int  k;
    int  pulses;
    bit  done;
    logic [7:0] idx;
    for (int j = 0; j < len; j++) begin
      idx = 8'(addr[7:0] + 8'(j));
      model[idx] = merge(model[idx], wbuf[j], en_n);
    end
    issue_req(addr, len, 1'b0);
    k = 0;
    pulses = 0;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (bus.sdr_core_busy_n) done = 1'b1;
      else begin
        bus.app_wr_data = (k < len) ? wbuf[k] : 32'h0;
        bus.app_wr_en_n = en_n;
        if (bus.app_wr_next_req) begin
          pulses++;
          k++;
        end
      end
    end
    checks++;
    if (!done || pulses != len)
      $display("[TB] FAIL wr_pulses addr=%0h: got %0d pulses (done=%0b), expected %0d", addr, pulses, done, len);
    else passed++;
  endtask

  task automatic read_burst(input logic [29:0] addr, input int len);
    int  cnt, first, last, beats, span_exp;
    bit  done;
    logic [31:0] exp_w;
    logic [7:0]  idx;
`ifdef SDRC_APP_RESP_BP_EN
    span_exp = 2 * len - 1;
`else
    span_exp = len;
`endif
    for (int j = 0; j < len; j++) begin
      idx = 8'(addr[7:0] + 8'(j));
      exp_q.push_back(model[idx]);
    end
    issue_req(addr, len, 1'b1);
    cnt = 0; first = -1; last = -1; beats = 0; done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      cnt++;
      if (bus.sdr_core_busy_n) done = 1'b1;
      else if (bus.app_rd_valid) begin
        beats++;
        if (first < 0) first = cnt;
        last = cnt;
        checks++;
        if (exp_q.size() == 0)
          $display("[TB] FAIL rd_extra addr=%0h: got beat %0d data %08h, expected no beat", addr, beats, bus.app_rd_data);
        else begin
          exp_w = exp_q.pop_front();
          if (bus.app_rd_data !== exp_w)
            $display("[TB] FAIL rd_data addr=%0h beat %0d: got %08h, expected %08h", addr, beats - 1, bus.app_rd_data, exp_w);
          else passed++;
        end
      end
    end
    checks++;
    if (first != RD_LAT + 1)
      $display("[TB] FAIL rd_latency addr=%0h: got %0d, expected %0d", addr, first, RD_LAT + 1);
    else passed++;
    checks++;
    if (beats != len || last - first + 1 != span_exp)
      $display("[TB] FAIL rd_beats addr=%0h: got %0d beats over %0d cycles, expected %0d over %0d",
               addr, beats, last - first + 1, len, span_exp);
    else passed++;
    checks++;
    if (!done || cnt != last + 1)
      $display("[TB] FAIL busy_n_release addr=%0h: got cycle %0d (done=%0b), expected %0d", addr, cnt, done, last + 1);
    else passed++;
    exp_q.delete();
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.app_req_ack !== 1'b0) $display("[TB] FAIL reset_ack: got %b, expected 0", bus.app_req_ack);
    else passed++;
    checks++;
    if (bus.app_wr_next_req !== 1'b0) $display("[TB] FAIL reset_wr_next: got %b, expected 0", bus.app_wr_next_req);
    else passed++;
    checks++;
    if (bus.app_rd_valid !== 1'b0) $display("[TB] FAIL reset_rd_valid: got %b, expected 0", bus.app_rd_valid);
    else passed++;
    checks++;
    if (bus.app_rd_data !== 32'h0) $display("[TB] FAIL reset_rd_data: got %08h, expected 0", bus.app_rd_data);
    else passed++;
    checks++;
    if (bus.sdr_core_busy_n !== 1'b1) $display("[TB] FAIL reset_busy_n: got %b, expected 1", bus.sdr_core_busy_n);
    else passed++;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    wbuf[0] = 32'h11223344; wbuf[1] = 32'h22334455; wbuf[2] = 32'h33445566;
    wbuf[3] = 32'h44556677; wbuf[4] = 32'h55667788;
    write_burst(30'h10, 5, 4'h0);
    read_burst(30'h10, 5);
  endtask

  task automatic test_byte_mask;
    wbuf[0] = 32'h00000000;
    write_burst(30'h20, 1, 4'h0);
    wbuf[0] = 32'hAABBCCDD;
    write_burst(30'h20, 1, 4'b1010);
    read_burst(30'h20, 1);
  endtask

  task automatic test_wrap;
    for (int j = 0; j < 4; j++) wbuf[j] = $urandom;
    write_burst(30'hFE, 4, 4'h0);
    read_burst(30'hFE, 4);
  endtask

  task automatic test_len_zero;
    int stray;
    issue_req(30'h30, 0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.sdr_core_busy_n !== 1'b1 || bus.app_req_ack !== 1'b0)
      $display("[TB] FAIL len0_release: got busy_n=%b ack=%b, expected busy_n=1 ack=0",
               bus.sdr_core_busy_n, bus.app_req_ack);
    else passed++;
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.app_wr_next_req || bus.app_rd_valid || bus.app_req_ack) stray++;
      @(negedge clk);
    end
    checks++;
    if (stray != 0) $display("[TB] FAIL len0_quiet: got %0d active strobe cycles, expected 0", stray);
    else passed++;
  endtask

  task automatic test_reset_mid_burst;
    int seen;
    logic [31:0] exp_w;
    for (int j = 0; j < 8; j++) wbuf[j] = $urandom;
    write_burst(30'h40, 8, 4'h0);
    for (int j = 0; j < 8; j++) exp_q.push_back(model[8'h40 + j]);
    issue_req(30'h40, 8, 1'b1);
    seen = 0;
    for (int c = 0; c < 100 && seen < 3; c++) begin
      @(negedge clk);
      if (bus.app_rd_valid) begin
        seen++;
        exp_w = exp_q.pop_front();
        checks++;
        if (bus.app_rd_data !== exp_w)
          $display("[TB] FAIL midrst_data beat %0d: got %08h, expected %08h", seen - 1, bus.app_rd_data, exp_w);
        else passed++;
      end
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (seen != 3 || bus.app_rd_valid !== 1'b0 || bus.sdr_core_busy_n !== 1'b1 || bus.app_rd_data !== 32'h0)
      $display("[TB] FAIL midrst_outputs: got beats=%0d valid=%b busy_n=%b data=%08h, expected 3/0/1/0",
               seen, bus.app_rd_valid, bus.sdr_core_busy_n, bus.app_rd_data);
    else passed++;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    read_burst(30'h40, 2);
  endtask

  initial begin
    clk = 1'b0;
    reset_n = 1'b0;
    bus.app_req      = 1'b0;
    bus.app_req_addr = '0;
    bus.app_req_len  = '0;
    bus.app_req_wr_n = 1'b1;
    bus.app_wr_data  = '0;
    bus.app_wr_en_n  = '1;

    test_reset;
    test_write_read;
    test_byte_mask;
    test_wrap;
    test_len_zero;
    test_reset_mid_burst;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
